// File: rtl/proc_defs_pkg.sv
// Shared definitions for the instruction fetch path: default widths and FSM states.
package proc_defs;

  localparam int unsigned DEF_DATA_W = 9;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fetch_unit_buffer.sv
// Small synchronous FIFO holding fetched {word, address} pairs; flush beats push.
module fetch_buffer #(
  parameter  int unsigned W     = 14,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [W-1:0]     i_din,
  output logic [CNT_W-1:0] o_count,
  output logic [W-1:0]     o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: drives a 1-cycle-latency ROM and streams words
// with their addresses over valid/ready, with wrap/stop sequencing and redirect.
module instr_fetch_unit
  import proc_defs::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned LAST_ADDR = 2**ADDR_W - 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic [ADDR_W-1:0] o_rom_address,
  input  logic [DATA_W-1:0] i_rom_q,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = DATA_W + ADDR_W;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_fetch_ptr;
  logic [ADDR_W-1:0]   r_infl_addr;
  logic                r_infl_vld;
  logic                r_halted;
  logic                w_issue;
  logic                w_pop;
  logic                w_valid;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic [OCC_W-1:0]    w_occ;
  logic [CNT_W-1:0]    w_count;
  logic [ENT_W-1:0]    w_head;

  assign w_valid   = (w_count != '0);
  assign w_pop     = w_valid && i_ready;
  // Buffer occupancy after this edge if nothing new is issued: the credit check.
  assign w_occ     = OCC_W'(w_count) + OCC_W'(r_infl_vld) - OCC_W'(w_pop);
  assign w_ptr_inc = (!i_mode && (r_fetch_ptr == ADDR_W'(LAST_ADDR)))
                     ? '0 : r_fetch_ptr + ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= RUN;
    else         r_state <= w_next_state;
  end

  // DRAIN->HALT looks at post-edge occupancy so Halted follows the last transfer directly.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      RUN: begin
        w_issue = i_enable && !i_load && (w_occ < OCC_W'(BUF_DEPTH));
        if (w_issue && i_mode && (r_fetch_ptr == ADDR_W'(LAST_ADDR)))
          w_next_state = DRAIN;
      end
      DRAIN:   if (w_occ == '0) w_next_state = HALT;
      HALT:    w_next_state = HALT;
      default: w_next_state = RUN;
    endcase
    if (i_load) w_next_state = RUN;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_ptr <= '0;
      r_infl_addr <= '0;
      r_infl_vld  <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_halted <= (w_next_state == HALT);
      if (i_load) begin
        r_fetch_ptr <= i_load_addr;
        r_infl_vld  <= 1'b0;
      end else begin
        r_infl_vld <= w_issue;
        if (w_issue) begin
          r_infl_addr <= r_fetch_ptr;
          r_fetch_ptr <= w_ptr_inc;
        end
      end
    end
  end

  fetch_buffer #(
    .W     (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (r_infl_vld),
    .i_pop   (w_pop),
    .i_flush (i_load),
    .i_din   ({i_rom_q, r_infl_addr}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign o_rom_address = r_fetch_ptr;
  assign o_valid       = w_valid;
  assign o_dout        = w_head[ADDR_W +: DATA_W];
  assign o_pc          = w_head[ADDR_W-1:0];
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; u_dut uses default LAST_ADDR, u_dut5 uses LAST_ADDR=5.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, enable, mode, load, ready;
  logic [4:0] load_addr;
  logic [4:0] rom_addr_a, pc_a, rom_addr_b, pc_b;
  logic [8:0] rom_q_a, rom_q_b, dout_a, dout_b;
  logic       valid_a, halted_a, valid_b, halted_b;
  int         vectors = 0;
  int         errors  = 0;
  int         exp_n;
  logic       hold;
  logic [8:0] held;

  always #5 clk = ~clk;

  // ROM contents: ROM[i] = i + 100, registered read.
  always @(posedge clk) rom_q_a <= 9'(rom_addr_a) + 9'd100;
  always @(posedge clk) rom_q_b <= 9'(rom_addr_b) + 9'd100;

  instr_fetch_unit u_dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_mode(mode),
    .i_load(load), .i_load_addr(load_addr), .o_rom_address(rom_addr_a),
    .i_rom_q(rom_q_a), .o_dout(dout_a), .o_valid(valid_a), .i_ready(ready),
    .o_pc(pc_a), .o_halted(halted_a)
  );

  instr_fetch_unit #(.LAST_ADDR(5)) u_dut5 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_mode(mode),
    .i_load(load), .i_load_addr(load_addr), .o_rom_address(rom_addr_b),
    .i_rom_q(rom_q_b), .o_dout(dout_b), .o_valid(valid_b), .i_ready(ready),
    .o_pc(pc_b), .o_halted(halted_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; load = 1'b0; enable = 1'b0; ready = 1'b0; load_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mode = 1'b0;
    apply_reset();
    chk("rst_valid", valid_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_addr", rom_addr_a, 0);
    chk("rst_halted", halted_a, 0);
    chk("rst_halted5", halted_b, 0);

    // 1: free-running wrap mode, one word per cycle, PC wraps 31 -> 0
    enable = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      chk($sformatf("t1_valid[%0d]", k), valid_a, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        chk($sformatf("t1_pc[%0d]", k), pc_a, (k - 2) % 32);
        chk($sformatf("t1_dout[%0d]", k), dout_a, 100 + ((k - 2) % 32));
      end
    end

    // 2: Ready low/high in 3-cycle phases; contiguous stream, stable while stalled
    apply_reset();
    enable = 1'b1;
    exp_n = 0; hold = 1'b0; held = '0;
    for (int k = 0; k < 30; k++) begin
      if (hold) begin
        chk($sformatf("t2_hold_valid[%0d]", k), valid_a, 1);
        chk($sformatf("t2_hold_dout[%0d]", k), dout_a, held);
      end
      ready = ((k / 3) % 2) == 1;
      if (valid_a && ready) begin
        chk($sformatf("t2_pc[%0d]", k), pc_a, exp_n);
        chk($sformatf("t2_dout[%0d]", k), dout_a, 100 + exp_n);
        exp_n++;
      end
      hold = valid_a && !ready;
      held = dout_a;
      @(negedge clk);
    end
    chk("t2_transfers", exp_n, 15);

    // 3: stop mode with LAST_ADDR=5 delivers PC 0..5 then halts
    apply_reset();
    mode = 1'b1; enable = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("t3_valid[%0d]", k), valid_b, (k >= 2 && k <= 7) ? 1 : 0);
      if (k >= 2 && k <= 7) begin
        chk($sformatf("t3_pc[%0d]", k), pc_b, k - 2);
        chk($sformatf("t3_dout[%0d]", k), dout_b, 100 + k - 2);
      end
      chk($sformatf("t3_halted[%0d]", k), halted_b, (k >= 8) ? 1 : 0);
    end
    chk("t3_addr_frozen", rom_addr_b, 6);

    // 5: redirect out of HALT to address 3
    load = 1'b1; load_addr = 5'd3;
    @(negedge clk);
    load = 1'b0;
    chk("t5_halted_clr", halted_b, 0);
    chk("t5_valid0", valid_b, 0);
    chk("t5_addr", rom_addr_b, 3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t5_valid[%0d]", k), valid_b, (k >= 2 && k <= 4) ? 1 : 0);
      if (k >= 2 && k <= 4) begin
        chk($sformatf("t5_pc[%0d]", k), pc_b, k + 1);
        chk($sformatf("t5_dout[%0d]", k), dout_b, 100 + k + 1);
      end
      chk($sformatf("t5_halted[%0d]", k), halted_b, (k >= 5) ? 1 : 0);
    end

    // 4: redirect to 20 with a word buffered and a read in flight
    apply_reset();
    mode = 1'b0; enable = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_pre_valid", valid_a, 1);
    chk("t4_pre_pc", pc_a, 0);
    load = 1'b1; load_addr = 5'd20; ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t4_flush_valid", valid_a, 0);
    chk("t4_addr", rom_addr_a, 20);
    @(negedge clk);
    chk("t4_gap_valid", valid_a, 0);
    @(negedge clk);
    chk("t4_valid", valid_a, 1);
    chk("t4_pc20", pc_a, 20);
    chk("t4_dout120", dout_a, 120);
    @(negedge clk);
    chk("t4_pc21", pc_a, 21);
    chk("t4_dout121", dout_a, 121);
    @(negedge clk);
    chk("t4_pc22_valid", valid_a, 1);
    chk("t4_pc22", pc_a, 22);

    // 6: reset mid-stream, then restart from address 0
    reset = 1'b1;
    @(negedge clk);
    chk("t6_valid", valid_a, 0);
    chk("t6_pc", pc_a, 0);
    chk("t6_dout", dout_a, 0);
    chk("t6_addr", rom_addr_a, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_valid_gap", valid_a, 0);
    @(negedge clk);
    chk("t6_restart_valid", valid_a, 1);
    chk("t6_restart_pc", pc_a, 0);
    chk("t6_restart_dout", dout_a, 100);
    @(negedge clk);
    chk("t6_next_pc", pc_a, 1);
    chk("t6_next_dout", dout_a, 101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised successor to the free-running ROM address counter that feeds the processor's DIN.
- Drives a synchronous instruction ROM with registered address, read latency 1 cycle.
- Buffers the returned words and presents them on a valid/ready stream.
- Supports wrap-around or stop-at-end sequencing, plus an address redirect (Load) that flushes all in-flight words.

Parameters:
DATA_W, 9, instruction word width
ADDR_W, 5, ROM address width
BUF_DEPTH, 2, output buffer entries (power of two, >=2)
LAST_ADDR, 2**ADDR_W-1, final address used in stop mode

Ports:
Clock  in  1  single clock; all state changes on its rising edge
Reset  in  1  synchronous, active-high reset
Enable  in  1  permits new ROM reads; buffered words still drain when low
Mode  in  1  0 = wrap LAST_ADDR->0; 1 = stop after LAST_ADDR
Load  in  1  redirect fetch to LoadAddr; flushes buffer and in-flight read
LoadAddr  in  ADDR_W  redirect target
rom_address  out  ADDR_W  ROM address, equals fetch pointer
rom_q  in  DATA_W  ROM data, valid the cycle after address was issued
DOUT  out  DATA_W  head-of-buffer word
Valid  out  1  DOUT holds a word
Ready  in  1  consumer accepts; transfer when Valid&&Ready at edge
PC  out  ADDR_W  ROM address of word on DOUT
Halted  out  1  stop mode finished; buffer empty; nothing in flight

Behaviour:
- Reset (overrides everything):
  - fetch_ptr=0, buffer empty, inflight=0, state=RUN.
  - Valid=0, Halted=0, DOUT=0, PC=0, rom_address=0.
- Issue condition: state==RUN && Enable && !Load && (count + inflight - pop) < BUF_DEPTH.
  - pop = Valid && Ready.
- On issue:
  - fetch_ptr increments.
  - Wrap: in Mode 0, fetch_ptr==LAST_ADDR goes to 0 (also modulo 2**ADDR_W).
  - The issued address is tagged into a 1-deep inflight register.
- Capture: an inflight read is written into the buffer, with its address, at the next edge (rom_q valid).
- Latency:
  - Issue at edge t; Valid rises in the cycle after edge t+1.
  - First word 2 cycles after Reset drops, with Enable=1.
- Throughput: 1 word/cycle sustained with Ready=1 and BUF_DEPTH=2.
- Backpressure: Ready=0 holds DOUT/PC stable; issue stops once the buffer is full. No word is dropped or duplicated.
- FSM states RUN, DRAIN, HALT:
  - RUN->DRAIN: Mode==1 and LAST_ADDR issued.
  - DRAIN->HALT: count==0 && inflight==0.
  - In Mode 0, RUN is never left.
  - HALT: Halted=1, no issue, Valid=0.
  - Mode changes affect only future issues.
- Load (any state, priority over issue):
  - A transfer in the same cycle still completes (the consumer got the word).
  - The buffer and the inflight read are discarded. rom_q arriving next cycle is ignored.
  - fetch_ptr=LoadAddr, state=RUN, Halted=0.
  - Valid=0 the next cycle. First redirected word is Valid 2 cycles after the first post-Load issue.
- Enable=0: issue stops, the inflight read completes, the buffer drains normally; no effect on Halted.
- Simultaneous push+pop when full is legal; count is unchanged.
- Load with LoadAddr > LAST_ADDR in Mode 1: fetch proceeds until wrap modulo 2**ADDR_W, then continues to LAST_ADDR. No error flag.

Decomposition:
- Shared package proc_defs:
  - DATA_W=9 and ADDR_W=5 defaults.
  - FSM state encodings RUN/DRAIN/HALT.
- Sub-module fetch_buffer: synchronous FIFO, DATA_W+ADDR_W wide, BUF_DEPTH deep.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push.
- Top level holds the fetch pointer, inflight tag, credit check and FSM.

Test Plan:
1. Reset, then Enable=1, Ready=1, Mode=0, ROM[i]=i+100 -> Valid rises 2 cycles later; DOUT 100,101,... one per cycle; PC 0..31 then wraps to 0.
2. Ready toggled 0/1 every 3 cycles -> the accepted DOUT sequence is contiguous 100,101,...; no gaps or duplicates; DOUT stable while Ready=0.
3. Mode=1, LAST_ADDR=5 -> exactly 6 words (PC 0..5) delivered; Halted=1 the cycle after the last transfer; rom_address no longer advances.
4. Load with LoadAddr=20 while the buffer is full and a read is in flight -> pre-Load words never appear; next accepted word has PC=20, DOUT=120.
5. Load while Halted, LoadAddr=3 -> Halted=0 next cycle; words PC 3..LAST_ADDR delivered; Halted re-asserts.
6. Reset asserted mid-stream with Valid=1 -> next cycle Valid=0, PC=0; restart begins at address 0.
